// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier (IEEE-style encoding).
// S1 unpacks and classifies both operands, S2 multiplies the significands
// and sums the exponents, S3 normalizes, rounds to nearest-even and packs.
// A single global stall freezes every stage whenever the output register
// holds a result the consumer has not yet taken.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [3:0]               flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;

  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);
  localparam logic signed [EW-1:0] EXP_INF  = EW'((1 << EXP_W) - 1);

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Round-to-nearest-even on the kept fraction; the extra MSB is the carry-out.
  function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] frac,
                                               input logic             g,
                                               input logic             r,
                                               input logic             s);
    logic up;
    up = g & (r | s | frac[0]);
    return {1'b0, frac} + {{MAN_W{1'b0}}, up};
  endfunction

  // Saturate an out-of-range exponent to signed infinity or signed zero and
  // pack the {flags, word} pair for the finite path.
  function automatic logic [W+3:0] pack_sat(input logic                 sign,
                                            input logic signed [EW-1:0] e,
                                            input logic [MAN_W-1:0]     frac,
                                            input logic                 inexact);
    if (e >= EXP_INF)
      return {4'b0101, sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    if (e < EXP_ONE)
      return {4'b0011, sign, {(EXP_W+MAN_W){1'b0}}};
    return {3'b000, inexact, sign, e[EXP_W-1:0], frac};
  endfunction

  // Pipeline control
  logic adv;
  logic vld_p0, vld_p1, vld_p2;

  assign adv       = !vld_p2 | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2;

  // ---------------------------------------------------------------- S1
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic inf_zero_s1, nan_s1, invalid_s1, inf_s1, zero_s1;

  assign a_exp = a[W-2 -: EXP_W];
  assign b_exp = b[W-2 -: EXP_W];
  assign a_man = a[MAN_W-1:0];
  assign b_man = b[MAN_W-1:0];

  assign a_nan  = (&a_exp) & (|a_man);
  assign b_nan  = (&b_exp) & (|b_man);
  assign a_snan = a_nan & ~a_man[MAN_W-1];
  assign b_snan = b_nan & ~b_man[MAN_W-1];
  assign a_inf  = (&a_exp) & ~(|a_man);
  assign b_inf  = (&b_exp) & ~(|b_man);
  // A zero exponent covers both true zero and subnormals, which flush to zero.
  assign a_zero = ~(|a_exp);
  assign b_zero = ~(|b_exp);

  assign inf_zero_s1 = (a_inf & b_zero) | (a_zero & b_inf);
  assign nan_s1      = a_nan | b_nan | inf_zero_s1;
  assign invalid_s1  = a_snan | b_snan | inf_zero_s1;
  assign inf_s1      = (a_inf | b_inf) & ~nan_s1;
  assign zero_s1     = (a_zero | b_zero) & ~nan_s1;

  logic               sign_p0;
  logic [EXP_W-1:0]   a_exp_p0, b_exp_p0;
  logic [MAN_W:0]     a_sig_p0, b_sig_p0;
  logic               nan_p0, invalid_p0, inf_p0, zero_p0;

  // Stage valid bits advance together under the global stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // S1 register: unpacked operands with hidden bit restored, plus class bits.
  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p0    <= a[W-1] ^ b[W-1];
      a_exp_p0   <= a_exp;
      b_exp_p0   <= b_exp;
      a_sig_p0   <= {1'b1, a_man};
      b_sig_p0   <= {1'b1, b_man};
      nan_p0     <= nan_s1;
      invalid_p0 <= invalid_s1;
      inf_p0     <= inf_s1;
      zero_p0    <= zero_s1;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [PW-1:0]        prod_s2;
  logic signed [EW-1:0] exp_s2;

  assign prod_s2 = PW'(a_sig_p0) * PW'(b_sig_p0);
  assign exp_s2  = $signed({2'b00, a_exp_p0}) + $signed({2'b00, b_exp_p0}) - BIAS;

  logic                 sign_p1;
  logic [PW-1:0]        prod_p1;
  logic signed [EW-1:0] exp_p1;
  logic                 nan_p1, invalid_p1, inf_p1, zero_p1;

  // S2 register: full-width significand product and biased exponent sum.
  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1    <= sign_p0;
      prod_p1    <= prod_s2;
      exp_p1     <= exp_s2;
      nan_p1     <= nan_p0;
      invalid_p1 <= invalid_p0;
      inf_p1     <= inf_p0;
      zero_p1    <= zero_p0;
    end
  end

  // ---------------------------------------------------------------- S3
  logic                 msb_s3;
  logic [PW-2:0]        norm_s3;
  logic signed [EW-1:0] exp_norm_s3, exp_fin_s3;
  logic [MAN_W-1:0]     frac_s3;
  logic                 g_s3, r_s3, st_s3;
  logic [MAN_W:0]       rnd_s3;
  logic [W+3:0]         out_s3;

  // Product is in [1,4): drop the leading one, shifting left when it sits
  // one place lower so the fraction always starts at the same bit.
  assign msb_s3      = prod_p1[PW-1];
  assign norm_s3     = msb_s3 ? prod_p1[PW-2:0] : {prod_p1[PW-3:0], 1'b0};
  assign exp_norm_s3 = exp_p1 + (msb_s3 ? EXP_ONE : EXP_ZERO);
  assign frac_s3     = norm_s3[PW-2 -: MAN_W];
  assign g_s3        = norm_s3[MAN_W];
  assign r_s3        = norm_s3[MAN_W-1];
  assign st_s3       = |norm_s3[MAN_W-2:0];
  assign rnd_s3      = round_rne(frac_s3, g_s3, r_s3, st_s3);
  assign exp_fin_s3  = exp_norm_s3 + (rnd_s3[MAN_W] ? EXP_ONE : EXP_ZERO);

  // Special cases override the arithmetic path in NaN > inf > zero order.
  always_comb begin
    out_s3 = pack_sat(sign_p1, exp_fin_s3, rnd_s3[MAN_W-1:0], g_s3 | r_s3 | st_s3);
    if (nan_p1)
      out_s3 = {invalid_p1, 3'b000, QNAN};
    else if (inf_p1)
      out_s3 = {4'b0000, sign_p1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (zero_p1)
      out_s3 = {4'b0000, sign_p1, {(EXP_W+MAN_W){1'b0}}};
  end

  // S3 register: output word and flags, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      flags  <= '0;
    end else if (adv && vld_p1) begin
      flags  <= out_s3[W+3:W];
      result <= out_s3[W-1:0];
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe (single-precision configuration).
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  // Reference: exact integer product of the significands, rounded by
  // comparing the discarded remainder against one half ulp.
  function automatic logic [35:0] model_mul(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e, sh;
    logic [22:0] fx, fy;
    logic s, x_nan, y_nan, x_snan, y_snan, x_inf, y_inf, x_zero, y_zero, bad;
    longint unsigned p, q, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = x[22:0];
    fy = y[22:0];
    x_nan  = (ex == 255) && (|fx);
    y_nan  = (ey == 255) && (|fy);
    x_snan = x_nan && !fx[22];
    y_snan = y_nan && !fy[22];
    x_inf  = (ex == 255) && !(|fx);
    y_inf  = (ey == 255) && !(|fy);
    x_zero = (ex == 0);
    y_zero = (ey == 0);
    bad    = (x_inf && y_zero) || (x_zero && y_inf);
    if (x_nan || y_nan || bad)
      return {(x_snan || y_snan || bad), 3'b000, 32'h7FC00000};
    s = x[31] ^ y[31];
    if (x_inf || y_inf) return {4'b0000, s, 8'hFF, 23'h0};
    if (x_zero || y_zero) return {4'b0000, s, 31'h0};
    p  = {40'd0, 1'b1, fx} * {40'd0, 1'b1, fy};
    sh = (p >= 64'h0000_8000_0000_0000) ? 24 : 23;
    e  = ex + ey - 127 + (sh - 23);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0)   return {4'b0011, s, 31'h0};
    return {3'b000, (rem != 64'd0), s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int unsigned k;
    v = $urandom;
    k = $urandom_range(0, 99);
    if (k < 5)       v[30:0] = '0;
    else if (k < 9)  v[30:23] = 8'h00;
    else if (k < 14) begin v[30:23] = 8'hFF; v[22:0] = '0; end
    else if (k < 18) begin v[30:23] = 8'hFF; v[0] = 1'b1; end
    else if (k < 50) v[30:23] = 8'(96 + $urandom_range(0, 63));
    else if (k < 55) v[22:0] = 23'h7FFFFF;
    else if (k < 60) v[22:0] = 23'h000001;
    return v;
  endfunction

  // Drive one cycle of inputs just after the rising edge, then wait for
  // the falling edge where outputs are sampled.
  task automatic tick(input logic r, input logic v, input logic [31:0] xa,
                      input logic [31:0] xb, input logic orr);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = v;
    a         = xa;
    b         = xb;
    out_ready = orr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) tick(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (result !== 32'h0) begin
      n_fail++; $display("FAIL reset_result: got %h want 00000000", result);
    end
    n_checks++;
    if (flags !== 4'h0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", flags);
    end
    tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[12];
    logic [31:0] vb[12];
    logic [31:0] vr[12];
    logic [3:0]  vf[12];
    int k;
    va = '{32'h3FC00000, 32'h3F800001, 32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 32'hFF800000,
           32'h00000001, 32'h7FA00000, 32'h7FC00000, 32'h80000000, 32'h3F800001, 32'h3F800003};
    vb = '{32'h40000000, 32'h3F800001, 32'h40000000, 32'h00800000, 32'h80000000, 32'h40000000,
           32'h40000000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h3FC00000, 32'h3FC00000};
    vr = '{32'h40400000, 32'h3F800002, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000,
           32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h3FC00002, 32'h3FC00004};
    vf = '{4'b0000, 4'b0001, 4'b0101, 4'b0011, 4'b1000, 4'b0000,
           4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1, va[i], vb[i], 1'b1);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL dir_accept[%0d]: in_ready %b want 1", i, in_ready);
      end
      k = 0;
      do begin
        tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        k++;
      end while (out_valid !== 1'b1 && k < 10);
      n_checks++;
      if (k != 3) begin
        n_fail++; $display("FAIL dir_latency[%0d]: %0d cycles want 3", i, k);
      end
      n_checks++;
      if (result !== vr[i]) begin
        n_fail++; $display("FAIL dir_result[%0d] %h*%h: got %h want %h", i, va[i], vb[i], result, vr[i]);
      end
      n_checks++;
      if (flags !== vf[i]) begin
        n_fail++; $display("FAIL dir_flags[%0d] %h*%h: got %b want %b", i, va[i], vb[i], flags, vf[i]);
      end
    end
    tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int delivered, accepted, first_c, last_c;
    logic v, orr;
    logic [31:0] xa, xb;
    // Full-rate stream with the consumer always ready.
    exp_q.delete();
    delivered = 0; accepted = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 14; c++) begin
      v = (c < 8);
      xa = rand_op(); xb = rand_op();
      tick(1'b0, v, xa, xb, 1'b1);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_full_in_ready c%0d: got %b want 1", c, in_ready);
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_full_spurious c%0d: got %h/%b want none", c, result, flags);
        end else begin
          if ({flags, result} !== exp_q[0]) begin
            n_fail++; $display("FAIL b2b_full_result c%0d: got %b/%h want %b/%h", c, flags, result, exp_q[0][35:32], exp_q[0][31:0]);
          end
          void'(exp_q.pop_front());
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        delivered++;
      end
      if (v && in_ready) begin exp_q.push_back(model_mul(xa, xb)); accepted++; end
    end
    n_checks++;
    if (delivered != 8 || first_c != 3 || last_c != 10) begin
      n_fail++; $display("FAIL b2b_full_rate: got %0d results in c%0d..c%0d want 8 in c3..c10", delivered, first_c, last_c);
    end
    // Five operations with the consumer stalled for four cycles mid-stream.
    exp_q.delete();
    delivered = 0; accepted = 0;
    for (int c = 0; c < 20; c++) begin
      v   = (accepted < 5);
      orr = !(c >= 3 && c < 7);
      xa = rand_op(); xb = rand_op();
      tick(1'b0, v, xa, xb, orr);
      n_checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++; $display("FAIL b2b_stall_in_ready c%0d: got %b want %b", c, in_ready, (!out_valid || out_ready));
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_stall_duplicate c%0d: got %h/%b want none", c, result, flags);
        end else if ({flags, result} !== exp_q[0]) begin
          n_fail++; $display("FAIL b2b_stall_result c%0d: got %b/%h want %b/%h", c, flags, result, exp_q[0][35:32], exp_q[0][31:0]);
        end
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          delivered++;
        end
      end
      if (v && in_ready) begin exp_q.push_back(model_mul(xa, xb)); accepted++; end
    end
    n_checks++;
    if (delivered != 5 || accepted != 5) begin
      n_fail++; $display("FAIL b2b_stall_count: got %0d out/%0d in want 5/5", delivered, accepted);
    end
  endtask

  task automatic test_random();
    int delivered, accepted;
    logic v, orr;
    logic [31:0] xa, xb;
    exp_q.delete();
    delivered = 0; accepted = 0;
    for (int c = 0; c < 420; c++) begin
      v   = (c < 400) && ($urandom_range(0, 3) != 0);
      orr = (c >= 400) || ($urandom_range(0, 3) != 0);
      xa = rand_op(); xb = rand_op();
      tick(1'b0, v, xa, xb, orr);
      n_checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, (!out_valid || out_ready));
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_spurious c%0d: got %h/%b want none", c, result, flags);
        end else if ({flags, result} !== exp_q[0]) begin
          n_fail++; $display("FAIL rnd_result c%0d: got %b/%h want %b/%h", c, flags, result, exp_q[0][35:32], exp_q[0][31:0]);
        end
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          delivered++;
        end
      end
      if (v && in_ready) begin exp_q.push_back(model_mul(xa, xb)); accepted++; end
    end
    n_checks++;
    if (delivered != accepted) begin
      n_fail++; $display("FAIL rnd_count: got %0d results want %0d", delivered, accepted);
    end
  endtask

  task automatic test_reset_in_flight();
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b1, rand_op(), rand_op(), 1'b0);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL rif_accept c%0d: in_ready %b want 1", c, in_ready);
      end
    end
    tick(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rif_loaded: out_valid %b want 1", out_valid);
    end
    tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || flags !== 4'h0) begin
      n_fail++; $display("FAIL rif_cleared: got %b/%h/%b want 0/00000000/0000", out_valid, result, flags);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rif_in_ready: got %b want 1", in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rif_stale c%0d: out_valid %b want 0", c, out_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
